// File: rtl/p4_vswitch_pkg.sv
// p4_vswitch_pkg: shared types and constants for the virtual-switch P4 datapath
//   NUM_VSWITCH    number of P4 pipelines (fixed at 4)
//   vsw_idx_t      pipeline index
//   arb_state_t    output arbiter states
//   axis_beat_t    one AXI4-Stream beat at the default bus widths
//   VLAN_ID_N      VLAN ids steering traffic to pipeline N (shared with the input demux)
package p4_vswitch_pkg;

    localparam int NUM_VSWITCH = 4;
    localparam int AXIS_DATA_WIDTH = 256;
    localparam int AXIS_TUSER_WIDTH = 128;

    typedef logic [1:0] vsw_idx_t;

    typedef enum logic {IDLE, FWD} arb_state_t;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0]   tdata;
        logic [AXIS_DATA_WIDTH/8-1:0] tkeep;
        logic [AXIS_TUSER_WIDTH-1:0]  tuser;
        logic                         tlast;
    } axis_beat_t;

    localparam logic [11:0] VLAN_ID_0 = 12'h001;
    localparam logic [11:0] VLAN_ID_1 = 12'h002;
    localparam logic [11:0] VLAN_ID_2 = 12'h003;
    localparam logic [11:0] VLAN_ID_3 = 12'h004;

    function automatic vsw_idx_t next_idx(input vsw_idx_t i);
        return i + vsw_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational round-robin pick over four requests
//   req      request vector, bit N = pipeline N
//   rr_ptr   highest-priority index
//   grant    first requesting index scanning rr_ptr, rr_ptr+1, ... mod 4
//   any_req  at least one request present
module rr_arbiter4
    import p4_vswitch_pkg::*;
(
    input  logic [NUM_VSWITCH-1:0] req,
    input  vsw_idx_t               rr_ptr,
    output vsw_idx_t               grant,
    output logic                   any_req
);

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant = rr_ptr;
        for (int i = NUM_VSWITCH - 1; i >= 0; i--)
            if (req[rr_ptr + vsw_idx_t'(i)]) grant = rr_ptr + vsw_idx_t'(i);
    end

    assign any_req = |req;

endmodule

// File: rtl/output_p4_arbiter.sv
// output_p4_arbiter: packet-granular round-robin merge of four P4 pipeline streams
//   axis_aclk, axis_reset          clock, synchronous active-high reset
//   s_axis_N_*  (N=0..3)           pipeline N input streams
//   m_axis_*                       merged output stream toward the output queues
//   pkt_cnt_N   (N=0..3)           per-input packet counters, present only when
//                                  OUTPUT_P4_ARBITER_PKT_CNT_EN is defined
module output_p4_arbiter
    import p4_vswitch_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128
) (
    input  logic                            axis_aclk,
    input  logic                            axis_reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_0_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_0_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_0_tuser,
    input  logic                            s_axis_0_tvalid,
    input  logic                            s_axis_0_tlast,
    output logic                            s_axis_0_tready,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_1_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_1_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_1_tuser,
    input  logic                            s_axis_1_tvalid,
    input  logic                            s_axis_1_tlast,
    output logic                            s_axis_1_tready,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_2_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_2_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_2_tuser,
    input  logic                            s_axis_2_tvalid,
    input  logic                            s_axis_2_tlast,
    output logic                            s_axis_2_tready,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_3_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_3_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_3_tuser,
    input  logic                            s_axis_3_tvalid,
    input  logic                            s_axis_3_tlast,
    output logic                            s_axis_3_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready
`ifdef OUTPUT_P4_ARBITER_PKT_CNT_EN
    ,
    output logic [31:0]                     pkt_cnt_0,
    output logic [31:0]                     pkt_cnt_1,
    output logic [31:0]                     pkt_cnt_2,
    output logic [31:0]                     pkt_cnt_3
`endif
);

    logic [C_AXIS_DATA_WIDTH-1:0]   in_tdata [NUM_VSWITCH];
    logic [C_AXIS_DATA_WIDTH/8-1:0] in_tkeep [NUM_VSWITCH];
    logic [C_AXIS_TUSER_WIDTH-1:0]  in_tuser [NUM_VSWITCH];
    logic [NUM_VSWITCH-1:0]         in_tvalid;
    logic [NUM_VSWITCH-1:0]         in_tlast;
    logic [NUM_VSWITCH-1:0]         in_tready;
    arb_state_t                     state;
    vsw_idx_t                       grant;
    vsw_idx_t                       rr_ptr;
    vsw_idx_t                       pick;
    logic                           any_req;
    logic                           fwd;
    logic                           done;

    assign in_tdata  = '{s_axis_0_tdata, s_axis_1_tdata, s_axis_2_tdata, s_axis_3_tdata};
    assign in_tkeep  = '{s_axis_0_tkeep, s_axis_1_tkeep, s_axis_2_tkeep, s_axis_3_tkeep};
    assign in_tuser  = '{s_axis_0_tuser, s_axis_1_tuser, s_axis_2_tuser, s_axis_3_tuser};
    assign in_tvalid = {s_axis_3_tvalid, s_axis_2_tvalid, s_axis_1_tvalid, s_axis_0_tvalid};
    assign in_tlast  = {s_axis_3_tlast, s_axis_2_tlast, s_axis_1_tlast, s_axis_0_tlast};

    rr_arbiter4 u_arb (
        .req     (in_tvalid),
        .rr_ptr  (rr_ptr),
        .grant   (pick),
        .any_req (any_req)
    );

    // Output is a pure mux of the granted source, forced to zero outside FWD.
    assign fwd           = state == FWD;
    assign m_axis_tdata  = fwd ? in_tdata[grant] : '0;
    assign m_axis_tkeep  = fwd ? in_tkeep[grant] : '0;
    assign m_axis_tuser  = fwd ? in_tuser[grant] : '0;
    assign m_axis_tvalid = fwd & in_tvalid[grant];
    assign m_axis_tlast  = fwd & in_tlast[grant];
    assign in_tready     = (fwd && m_axis_tready) ? 4'b0001 << grant : 4'b0000;
    assign done          = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    assign s_axis_0_tready = in_tready[0];
    assign s_axis_1_tready = in_tready[1];
    assign s_axis_2_tready = in_tready[2];
    assign s_axis_3_tready = in_tready[3];

    // IDLE spends one cycle latching the winner; FWD holds it until tlast handshakes.
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else if (!fwd) begin
            if (any_req) begin
                grant <= pick;
                state <= FWD;
            end
        end else if (done) begin
            rr_ptr <= next_idx(grant);
            state  <= IDLE;
        end
    end

`ifdef OUTPUT_P4_ARBITER_PKT_CNT_EN
    for (genvar i = 0; i < NUM_VSWITCH; i++) begin : g_cnt
        logic [31:0] cnt;
        always_ff @(posedge axis_aclk) begin
            if (axis_reset) cnt <= '0;
            else if (done && grant == vsw_idx_t'(i)) cnt <= cnt + 32'd1;
        end
    end

    assign pkt_cnt_0 = g_cnt[0].cnt;
    assign pkt_cnt_1 = g_cnt[1].cnt;
    assign pkt_cnt_2 = g_cnt[2].cnt;
    assign pkt_cnt_3 = g_cnt[3].cnt;
`endif

endmodule

// File: tb/tb_output_p4_arbiter.sv
// tb_output_p4_arbiter: randomized and directed stimulus against a packet-level arbitration model
module tb_output_p4_arbiter;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rst_next = 1'b1;
    logic [DW-1:0] d [4];
    logic [KW-1:0] k [4];
    logic [UW-1:0] u [4];
    logic [3:0]    vld = '0;
    logic [3:0]    lst = '0;
    logic [3:0]    rdy;
    logic [3:0]    hs = '0;
    logic [DW-1:0] m_d;
    logic [KW-1:0] m_k;
    logic [UW-1:0] m_u;
    logic          m_v, m_l;
    logic          m_r = 1'b1;
`ifdef OUTPUT_P4_ARBITER_PKT_CNT_EN
    logic [31:0]   pc [4];
`endif

    always #5 clk = ~clk;

    output_p4_arbiter dut (
        .axis_aclk(clk), .axis_reset(rst),
        .s_axis_0_tdata(d[0]), .s_axis_0_tkeep(k[0]), .s_axis_0_tuser(u[0]),
        .s_axis_0_tvalid(vld[0]), .s_axis_0_tlast(lst[0]), .s_axis_0_tready(rdy[0]),
        .s_axis_1_tdata(d[1]), .s_axis_1_tkeep(k[1]), .s_axis_1_tuser(u[1]),
        .s_axis_1_tvalid(vld[1]), .s_axis_1_tlast(lst[1]), .s_axis_1_tready(rdy[1]),
        .s_axis_2_tdata(d[2]), .s_axis_2_tkeep(k[2]), .s_axis_2_tuser(u[2]),
        .s_axis_2_tvalid(vld[2]), .s_axis_2_tlast(lst[2]), .s_axis_2_tready(rdy[2]),
        .s_axis_3_tdata(d[3]), .s_axis_3_tkeep(k[3]), .s_axis_3_tuser(u[3]),
        .s_axis_3_tvalid(vld[3]), .s_axis_3_tlast(lst[3]), .s_axis_3_tready(rdy[3]),
        .m_axis_tdata(m_d), .m_axis_tkeep(m_k), .m_axis_tuser(m_u),
        .m_axis_tvalid(m_v), .m_axis_tlast(m_l), .m_axis_tready(m_r)
`ifdef OUTPUT_P4_ARBITER_PKT_CNT_EN
        ,
        .pkt_cnt_0(pc[0]), .pkt_cnt_1(pc[1]), .pkt_cnt_2(pc[2]), .pkt_cnt_3(pc[3])
`endif
    );

    int vec = 0;
    int bad = 0;
    int cyc = 0;

    // source control
    int pkts [4] = '{0, 0, 0, 0};
    int rem [4] = '{0, 0, 0, 0};
    int hold [4] = '{0, 0, 0, 0};
    int plen [4] = '{0, 0, 0, 0};
    int gap_rem [4] = '{-1, -1, -1, -1};
    int gap_len [4] = '{0, 0, 0, 0};
    int vprob = 100;
    int mpat = 0;

    // reference model: who owns the output and who has priority next
    int owner = -1;
    int pri = 0;
    logic [31:0] mcnt [4] = '{0, 0, 0, 0};

    // observation logs
    int order[$];
    int mhs[$];
    int tfv = -1;
    int r3_early = 0;

    task automatic chk(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
        vec++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic int ord(input int i);
        return i < order.size() ? order[i] : -1;
    endfunction

    function automatic int mh(input int i);
        return i < mhs.size() ? mhs[i] : -1000;
    endfunction

    task automatic clear_log();
        order.delete();
        mhs.delete();
        tfv = -1;
        r3_early = 0;
    endtask

    task automatic check_cycle();
        logic [3:0] er;
        logic ev;
        er = '0;
        ev = 1'b0;
        if (owner >= 0) begin
            ev = vld[owner];
            er[owner] = m_r;
            chk("m_tdata", m_d, d[owner]);
            chk("m_tkeep", DW'(m_k), DW'(k[owner]));
            chk("m_tuser", DW'(m_u), DW'(u[owner]));
            chk("m_tlast", DW'(m_l), DW'(lst[owner]));
        end else begin
            chk("m_tdata_idle", m_d, '0);
            chk("m_tkeep_idle", DW'(m_k), '0);
            chk("m_tuser_idle", DW'(m_u), '0);
            chk("m_tlast_idle", DW'(m_l), '0);
        end
        chk("m_tvalid", DW'(m_v), DW'(ev));
        chk("s_tready", DW'(rdy), DW'(er));
`ifdef OUTPUT_P4_ARBITER_PKT_CNT_EN
        for (int n = 0; n < 4; n++) chk($sformatf("pkt_cnt_%0d", n), DW'(pc[n]), DW'(mcnt[n]));
`endif
        hs = vld & rdy;
        if (rdy[3] && order.size() == 0) r3_early = 1;
        if (m_v && m_r) begin
            mhs.push_back(cyc);
            if (m_l) order.push_back(int'(m_u[1:0]));
        end
        if (rst) begin
            owner = -1;
            pri = 0;
            for (int n = 0; n < 4; n++) mcnt[n] = '0;
        end else if (owner < 0) begin
            for (int i = 0; i < 4; i++)
                if (owner < 0 && vld[(pri + i) % 4]) owner = (pri + i) % 4;
        end else if (vld[owner] && m_r && lst[owner]) begin
            mcnt[owner] = mcnt[owner] + 32'd1;
            pri = (owner + 1) % 4;
            owner = -1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            for (int n = 0; n < 4; n++) begin
                pkts[n] = 0; rem[n] = 0; hold[n] = 0; vld[n] = 1'b0;
            end
            hs = '0;
        end
        rst = rst_next;
        for (int n = 0; n < 4; n++) begin
            if (hs[n]) begin
                rem[n]--;
                vld[n] = 1'b0;
                if (rem[n] == 0) pkts[n]--;
                else if (rem[n] == gap_rem[n]) hold[n] = gap_len[n];
            end
            if (!vld[n]) begin
                if (hold[n] > 0) hold[n]--;
                else if ((rem[n] > 0 || pkts[n] > 0) && $urandom_range(99) < vprob) begin
                    if (rem[n] == 0) begin
                        rem[n] = plen[n] > 0 ? plen[n] : int'($urandom_range(1, 6));
                        if (n == 2 && tfv < 0) tfv = cyc;
                    end
                    vld[n] = 1'b1;
                    d[n] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                    k[n] = $urandom;
                    u[n] = {$urandom, $urandom, $urandom, $urandom};
                    u[n][1:0] = 2'(n);
                    lst[n] = rem[n] == 1;
                end
            end
        end
        m_r = mpat == 0 ? 1'b1 : mpat == 1 ? ~m_r : 1'($urandom_range(1));
        @(negedge clk);
        check_cycle();
    endtask

    function automatic bit busy();
        bit b;
        b = owner >= 0 || vld != 0;
        for (int n = 0; n < 4; n++) b = b || rem[n] > 0 || pkts[n] > 0;
        return b;
    endfunction

    task automatic run_idle(input int maxc);
        int c;
        c = 0;
        while (busy() && c < maxc) begin
            step();
            c++;
        end
        chk("drain_timeout", DW'(c >= maxc), '0);
    endtask

    task automatic do_reset();
        rst_next = 1'b1;
        step();
        rst_next = 1'b0;
        step();
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin
            d[n] = '0; k[n] = '0; u[n] = '0;
        end
        step();
        rst_next = 1'b0;
        step();
        chk("reset_tvalid", DW'(m_v), '0);
        chk("reset_tready", DW'(rdy), '0);
        chk("reset_tdata", m_d, '0);
        chk("reset_rr_ptr", DW'(dut.rr_ptr), '0);

        // single 3-beat packet from input 2
        clear_log();
        plen = '{3, 3, 3, 3};
        pkts[2] = 1;
        run_idle(50);
        chk("t1_npkts", DW'(order.size()), 1);
        chk("t1_src", DW'(ord(0)), 2);
        chk("t1_latency", DW'(mh(0) - tfv), 1);
        chk("t1_contig", DW'(mh(2) - mh(0)), 2);
        chk("t1_rr_ptr", DW'(dut.rr_ptr), 3);

        // all four inputs continuously valid with 2-beat packets
        do_reset();
        clear_log();
        plen = '{2, 2, 2, 2};
        pkts = '{2, 2, 2, 2};
        run_idle(100);
        chk("t2_npkts", DW'(order.size()), 8);
        for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), DW'(ord(i)), DW'(i % 4));
        chk("t2_contig", DW'(mh(1) - mh(0)), 1);
        chk("t2_gap", DW'(mh(2) - mh(1)), 2);

        // input 1 stalls 4 cycles mid-packet while input 3 waits
        do_reset();
        clear_log();
        plen = '{0, 3, 0, 2};
        gap_rem[1] = 2;
        gap_len[1] = 4;
        pkts[1] = 1;
        pkts[3] = 1;
        run_idle(100);
        gap_rem[1] = -1;
        chk("t3_first", DW'(ord(0)), 1);
        chk("t3_second", DW'(ord(1)), 3);
        chk("t3_stall", DW'(mh(1) - mh(0)), 5);
        chk("t3_r3_early", DW'(r3_early), 0);

        // toggling downstream ready during a 5-beat packet
        clear_log();
        plen = '{5, 0, 0, 0};
        mpat = 1;
        pkts[0] = 1;
        run_idle(100);
        mpat = 0;
        chk("t4_beats", DW'(mhs.size()), 5);
        chk("t4_src", DW'(ord(0)), 0);

        // reset on beat 2 of a 4-beat packet
        clear_log();
        plen = '{4, 0, 0, 0};
        pkts[0] = 1;
        for (int i = 0; i < 20 && mhs.size() < 1; i++) step();
        chk("t5_beat1", DW'(mhs.size()), 1);
        rst_next = 1'b1;
        step();
        rst_next = 1'b0;
        step();
        chk("t5_tready", DW'(rdy), '0);
        chk("t5_tvalid", DW'(m_v), '0);
        clear_log();
        plen = '{1, 1, 1, 1};
        pkts[0] = 1;
        pkts[2] = 1;
        run_idle(50);
        chk("t5_first", DW'(ord(0)), 0);
        chk("t5_second", DW'(ord(1)), 2);

        // randomized traffic, gaps and backpressure
        plen = '{0, 0, 0, 0};
        vprob = 50;
        mpat = 2;
        for (int n = 0; n < 4; n++) pkts[n] = $urandom_range(3, 8);
        run_idle(5000);
        vprob = 100;
        mpat = 0;

`ifdef OUTPUT_P4_ARBITER_PKT_CNT_EN
        do_reset();
        plen = '{0, 0, 0, 0};
        pkts[3] = 7;
        pkts[0] = 2;
        run_idle(500);
        chk("t6_cnt3", DW'(pc[3]), 7);
        chk("t6_cnt0", DW'(pc[0]), 2);
        chk("t6_cnt1", DW'(pc[1]), 0);
        chk("t6_cnt2", DW'(pc[2]), 0);
        force dut.g_cnt[1].cnt = 32'hFFFF_FFFF;
        mcnt[1] = 32'hFFFF_FFFF;
        step();
        release dut.g_cnt[1].cnt;
        pkts[1] = 1;
        run_idle(50);
        chk("t6_wrap", DW'(pc[1]), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/output_p4_arbiter.md
Name: output_p4_arbiter

Overview:
Merges the four virtual-switch P4 pipeline output streams into one AXI4-Stream toward the output queues. It is the counterpart of the VLAN-ID input demux.
- Arbitration is round-robin at packet granularity. Once granted, an input owns the output until its tlast beat handshakes.
- No buffering. The data path is a registered-grant multiplexer, so the block adds zero data latency once a grant is held.

Parameters:
C_AXIS_DATA_WIDTH, 256, tdata width of all streams; tkeep is C_AXIS_DATA_WIDTH/8.
C_AXIS_TUSER_WIDTH, 128, tuser width of all streams.
NUM_VSWITCH, 4, number of pipeline inputs; fixed at 4 in this release, ports enumerated 0..3.

Ports:
axis_aclk  in  1  single clock for all logic
axis_reset  in  1  synchronous, active-high reset
s_axis_N_tdata  in  C_AXIS_DATA_WIDTH  pipeline N data (N=0..3, same set per N)
s_axis_N_tkeep  in  C_AXIS_DATA_WIDTH/8  pipeline N byte enables
s_axis_N_tuser  in  C_AXIS_TUSER_WIDTH  pipeline N sideband (dst port etc.)
s_axis_N_tvalid  in  1  pipeline N valid
s_axis_N_tlast  in  1  pipeline N end of packet
s_axis_N_tready  out  1  ready to pipeline N
m_axis_tdata  out  C_AXIS_DATA_WIDTH  merged data
m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  merged byte enables
m_axis_tuser  out  C_AXIS_TUSER_WIDTH  merged sideband
m_axis_tvalid  out  1  merged valid
m_axis_tlast  out  1  merged end of packet
m_axis_tready  in  1  downstream ready

Behaviour:
- State machine has two states, IDLE and FWD. Registers are state, grant[1:0] and rr_ptr[1:0] (the highest-priority input).
- Reset (axis_reset=1 at an edge): state=IDLE, grant=0, rr_ptr=0.
  - Outputs while in reset/IDLE: all s_axis_N_tready=0; m_axis_tvalid=0; m_axis_tdata/tkeep/tuser/tlast=0.
- IDLE:
  - If any s_axis_N_tvalid=1, set grant to the first valid input scanning rr_ptr, rr_ptr+1, ... modulo 4, then go to FWD next cycle.
  - No beat is transferred in the IDLE cycle, so there is one cycle of arbitration bubble per packet.
- FWD:
  - m_axis_* = s_axis_grant_*; m_axis_tvalid = s_axis_grant_tvalid.
  - s_axis_grant_tready = m_axis_tready; all other s_axis_N_tready = 0. Both are combinational from registered grant/state.
  - When m_axis_tvalid & m_axis_tready & m_axis_tlast: set rr_ptr = grant+1 (mod 4) and go to IDLE.
- Granted input drops tvalid mid-packet: grant is held, m_axis_tvalid=0, and no other input is served. There is no timeout.
- Single-beat packet (tlast on first beat): accepted in one FWD cycle, then IDLE.
- Simultaneous requests: strict rotation. With all four continuously valid, the service order after reset is 0,1,2,3,0,...
- Downstream backpressure: m_axis_tready=0 stalls the granted input via its tready. The output holds data stable per AXIS rules because it is a pure mux of a stable source.
- Reset mid-packet: grant is dropped immediately and the partial packet is truncated downstream. Upstream pipelines are reset by the same signal.
- Grant never changes while state=FWD except on the tlast handshake.

Optional Feature:
OUTPUT_P4_ARBITER_PKT_CNT_EN:
- Defined: adds output ports pkt_cnt_N (N=0..3), each 32-bit, out.
  - pkt_cnt_N increments by 1 on each tlast handshake from input N.
  - Wraps 0xFFFFFFFF -> 0.
  - Reset to 0.
- Undefined: ports and counters are absent. Arbitration behaviour is identical.

Decomposition:
- Shared package p4_vswitch_pkg:
  - NUM_VSWITCH
  - typedef vsw_idx_t (2-bit)
  - state enum (IDLE, FWD)
  - AXIS beat struct {tdata, tkeep, tuser, tlast}
  - VLAN id constants 12'h001..12'h004 (shared with the input demux)
- One sub-module: rr_arbiter4. Combinational round-robin pick from a 4-bit request vector and rr_ptr, returning grant index and any_req.

Test Plan:
1. Reset, then only input 2 sends a 3-beat packet with m_axis_tready=1 -> first output beat 1 cycle after tvalid; 3 consecutive beats on m_axis; s_axis_2_tready high only in FWD; return to IDLE; rr_ptr=3.
2. All inputs valid with 2-beat packets, continuously -> output packet order 0,1,2,3,0. Each packet is contiguous with a 1-cycle gap between packets.
3. Input 1 mid-packet: tvalid low 4 cycles while input 3 is valid -> m_axis_tvalid=0 for 4 cycles, s_axis_3_tready stays 0, packet 1 completes before packet 3.
4. m_axis_tready toggling 1010... during a 5-beat packet from input 0 -> no beat lost or duplicated; data stable while m_axis_tvalid=1 and tready=0.
5. axis_reset asserted on beat 2 of a 4-beat packet -> next cycle all tready=0, m_axis_tvalid=0. After release, input 0 has priority.
6. With OUTPUT_P4_ARBITER_PKT_CNT_EN: 7 packets on input 3 and 2 on input 0 -> pkt_cnt_3=7, pkt_cnt_0=2, others 0. Preload 0xFFFFFFFF on pkt_cnt_1 via force, send one packet on input 1 -> counter reads 0.
